// File: rtl/irq_ctrl.sv
// irq_ctrl: external interrupt controller in front of the picoRV32 irq inputs.
// Synchronises NIRQ asynchronous request lines, latches them as rising-edge
// or level requests, masks them with ENABLE and delivers one request at a
// time, lowest index first, through the CPU eoi handshake. Firmware reaches
// PENDING/ENABLE/MODE/ACTIVE/STATUS through a 32-byte window on the native bus.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   irq_in[NIRQ]           raw external requests (asynchronous to clk)
//   mem_valid/addr/wdata/wstrb, mem_ready/rdata   picoRV32 native bus slave
//   cpu_irq[NIRQ]          registered one-hot request to the CPU
//   cpu_eoi[NIRQ]          CPU in-service indication per line
module irq_ctrl #(
  parameter int unsigned NIRQ        = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            mem_valid,
  input  logic [31:0]     mem_addr,
  input  logic [31:0]     mem_wdata,
  input  logic [3:0]      mem_wstrb,
  output logic            mem_ready,
  output logic [31:0]     mem_rdata,
  output logic [NIRQ-1:0] cpu_irq,
  input  logic [NIRQ-1:0] cpu_eoi
);

  localparam int unsigned SEL_W = 3;

  // Register word indices within the window (addr[4:2])
  localparam logic [2:0] IDX_PENDING = 3'd0;
  localparam logic [2:0] IDX_ENABLE  = 3'd1;
  localparam logic [2:0] IDX_MODE    = 3'd2;
  localparam logic [2:0] IDX_ACTIVE  = 3'd3;
  localparam logic [2:0] IDX_STATUS  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELIVER = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  // Flops
  logic [NIRQ-1:0]  sync_q [SYNC_STAGES];
  logic [NIRQ-1:0]  sync_d [SYNC_STAGES];
  logic [NIRQ-1:0]  s_prev_q,   s_prev_d;
  logic [NIRQ-1:0]  pending_q,  pending_d;
  logic [NIRQ-1:0]  enable_q,   enable_d;
  logic [NIRQ-1:0]  mode_q,     mode_d;
  logic [NIRQ-1:0]  cpu_irq_q,  cpu_irq_d;
  logic [SEL_W-1:0] sel_q,      sel_d;
  state_e           state_q,    state_d;
  logic             mem_ready_q, mem_ready_d;
  logic [31:0]      mem_rdata_q, mem_rdata_d;

  // Combinational helpers
  logic [NIRQ-1:0]  s_c;
  logic [NIRQ-1:0]  edge_c;
  logic [NIRQ-1:0]  req_c;
  logic [NIRQ-1:0]  sel_oh_c;
  logic [NIRQ-1:0]  w1c_c;
  logic [NIRQ-1:0]  ack_clr_c;
  logic [NIRQ-1:0]  active_c;
  logic [SEL_W-1:0] winner_c;
  logic             hit_c, access_c, wr_en_c, rd_en_c, busy_c;
  logic             sel_en_c, sel_mode_c, sel_s_c, sel_eoi_c, abort_c;
  logic [2:0]       reg_idx_c;
  logic [31:0]      rd_val_c;
  logic             unused_bits;

  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:NIRQ]};

  // Synchroniser chain and rising-edge detect on the synchronised value
  always_comb begin
    sync_d[0] = irq_in;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign s_c      = sync_q[SYNC_STAGES-1];
  assign edge_c   = s_c & ~s_prev_q;
  assign s_prev_d = s_c;

  // Bus decode: one access per valid, the cycle after ready is blocked
  assign hit_c     = (mem_addr[31:5] == BASE_ADDR[31:5]);
  assign access_c  = mem_valid & hit_c & ~mem_ready_q;
  assign wr_en_c   = access_c & mem_wstrb[0];
  assign rd_en_c   = access_c & (mem_wstrb == 4'b0000);
  assign reg_idx_c = mem_addr[4:2];

  // Fixed priority: lowest index wins
  assign req_c = pending_q & enable_q;

  always_comb begin
    winner_c = '0;
    for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
      if (req_c[i]) begin
        winner_c = SEL_W'(i);
      end
    end
  end

  // Attributes of the line currently selected, via one-hot mask
  assign sel_oh_c   = NIRQ'(1) << sel_q;
  assign sel_en_c   = |(enable_q & sel_oh_c);
  assign sel_mode_c = |(mode_q & sel_oh_c);
  assign sel_s_c    = |(s_c & sel_oh_c);
  assign sel_eoi_c  = |(cpu_eoi & sel_oh_c);
  // Delivery is withdrawn if masked, or a level source went quiet
  assign abort_c    = ~sel_en_c | (~sel_mode_c & ~sel_s_c);

  assign busy_c   = (state_q != ST_IDLE);
  assign active_c = busy_c ? sel_oh_c : '0;

  // Delivery FSM next state
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cpu_irq_d = cpu_irq_q;
    ack_clr_c = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req_c) begin
          sel_d     = winner_c;
          cpu_irq_d = NIRQ'(1) << winner_c;
          state_d   = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        if (abort_c) begin
          cpu_irq_d = '0;
          state_d   = ST_IDLE;
        end else if (sel_eoi_c) begin
          cpu_irq_d = '0;
          ack_clr_c = sel_oh_c;
          state_d   = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (!sel_eoi_c) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        cpu_irq_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Register file updates; for edge lines a new edge beats any clear
  always_comb begin
    w1c_c    = '0;
    enable_d = enable_q;
    mode_d   = mode_q;
    if (wr_en_c) begin
      case (reg_idx_c)
        IDX_PENDING: w1c_c    = mem_wdata[NIRQ-1:0];
        IDX_ENABLE:  enable_d = mem_wdata[NIRQ-1:0];
        IDX_MODE:    mode_d   = mem_wdata[NIRQ-1:0];
        default:     ;
      endcase
    end
    pending_d = (mode_q & (edge_c | (pending_q & ~(w1c_c | ack_clr_c))))
              | (~mode_q & s_c);
  end

  // Read mux and bus response
  always_comb begin
    rd_val_c = '0;
    case (reg_idx_c)
      IDX_PENDING: rd_val_c = 32'(pending_q);
      IDX_ENABLE:  rd_val_c = 32'(enable_q);
      IDX_MODE:    rd_val_c = 32'(mode_q);
      IDX_ACTIVE:  rd_val_c = 32'(active_c);
      IDX_STATUS:  rd_val_c = 32'({busy_c, 4'b0000, sel_q});
      default:     rd_val_c = '0;
    endcase
    mem_ready_d = access_c;
    mem_rdata_d = rd_en_c ? rd_val_c : '0;
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      s_prev_q    <= '0;
      pending_q   <= '0;
      enable_q    <= '0;
      mode_q      <= '0;
      cpu_irq_q   <= '0;
      sel_q       <= '0;
      state_q     <= ST_IDLE;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      s_prev_q    <= s_prev_d;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      cpu_irq_q   <= cpu_irq_d;
      sel_q       <= sel_d;
      state_q     <= state_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign cpu_irq   = cpu_irq_q;
  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: register table, directed corner
// sequences and a randomized run, all compared every cycle against a
// behavioural model of the controller.
module tb_irq_ctrl;

  localparam int          NIRQ = 3;
  localparam int          SYNC = 2;
  localparam logic [31:0] BASE = 32'h0300_0000;

  logic            clk;
  logic            resetn;
  logic [NIRQ-1:0] irq_in;
  logic            mem_valid;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_ready;
  logic [31:0]     mem_rdata;
  logic [NIRQ-1:0] cpu_irq;
  logic [NIRQ-1:0] cpu_eoi;

  irq_ctrl #(
    .NIRQ        (NIRQ),
    .BASE_ADDR   (BASE),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .irq_in    (irq_in),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .cpu_irq   (cpu_irq),
    .cpu_eoi   (cpu_eoi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Requests: delayed input history; delivery: busy/acked flags plus line.
  logic [NIRQ-1:0] m_hist [SYNC];
  logic [NIRQ-1:0] m_sprev, m_pend, m_en, m_mode, m_irq;
  bit              m_busy, m_acked, m_ready;
  int              m_line;
  logic [31:0]     m_rdata;

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_hist[i] = '0;
    m_sprev = '0; m_pend = '0; m_en = '0; m_mode = '0; m_irq = '0;
    m_busy = 0; m_acked = 0; m_ready = 0; m_line = 0; m_rdata = '0;
  endtask

  task automatic model_step();
    logic [NIRQ-1:0] s, edg, req, w1c, ack, act;
    bit              acc, wr, rd;
    int              off;
    logic [31:0]     rv;
    s   = m_hist[SYNC-1];
    edg = s & ~m_sprev;
    acc = mem_valid && (mem_addr[31:5] == BASE[31:5]) && !m_ready;
    wr  = acc && mem_wstrb[0];
    rd  = acc && (mem_wstrb == 4'b0000);
    off = int'(mem_addr[4:0]) / 4;
    act = m_busy ? NIRQ'(1 << m_line) : '0;
    case (off)
      0:       rv = 32'(m_pend);
      1:       rv = 32'(m_en);
      2:       rv = 32'(m_mode);
      3:       rv = 32'(act);
      4:       rv = (m_busy ? 32'h80 : 32'h0) | 32'(m_line);
      default: rv = 32'h0;
    endcase
    req = m_pend & m_en;
    ack = '0;
    if (!m_busy) begin
      if (req != '0) begin
        for (int i = NIRQ - 1; i >= 0; i--) if (req[i]) m_line = i;
        m_busy = 1; m_acked = 0;
        m_irq  = NIRQ'(1 << m_line);
      end
    end else if (!m_acked) begin
      if (!m_en[m_line] || (!m_mode[m_line] && !s[m_line])) begin
        m_busy = 0; m_irq = '0;
      end else if (cpu_eoi[m_line]) begin
        m_acked = 1; m_irq = '0; ack[m_line] = 1'b1;
      end
    end else if (!cpu_eoi[m_line]) begin
      m_busy = 0; m_acked = 0;
    end
    w1c = (wr && off == 0) ? mem_wdata[NIRQ-1:0] : '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (m_mode[i]) m_pend[i] = edg[i] | (m_pend[i] & ~(w1c[i] | ack[i]));
      else           m_pend[i] = s[i];
    end
    if (wr && off == 1) m_en   = mem_wdata[NIRQ-1:0];
    if (wr && off == 2) m_mode = mem_wdata[NIRQ-1:0];
    m_ready = acc;
    m_rdata = rd ? rv : 32'h0;
    for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = irq_in;
    m_sprev   = s;
  endtask

  // One clock: advance model, then compare outputs after the edge
  task automatic tick();
    @(posedge clk);
    if (!resetn) model_reset();
    else         model_step();
    #1;
    check("model_cpu_irq",   32'(cpu_irq),   32'(m_irq));
    check("model_mem_ready", 32'(mem_ready), 32'(m_ready));
    check("model_mem_rdata", mem_rdata,      m_rdata);
  endtask

  task automatic bus_wr(input logic [4:0] off, input logic [31:0] d, input logic [3:0] strb);
    mem_valid = 1'b1; mem_addr = BASE | 32'(off); mem_wdata = d; mem_wstrb = strb;
    tick();
    mem_valid = 1'b0; mem_wstrb = 4'b0000;
    tick();
  endtask

  task automatic bus_rd(input logic [4:0] off, output logic [31:0] d);
    mem_valid = 1'b1; mem_addr = BASE | 32'(off); mem_wstrb = 4'b0000;
    tick();
    d = mem_rdata;
    mem_valid = 1'b0;
    tick();
  endtask

  task automatic wait_irq(input logic [NIRQ-1:0] exp, input string name);
    int n = 0;
    while (cpu_irq == '0 && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(cpu_irq), 32'(exp));
  endtask

  task automatic t1();
    logic [31:0] d;
    bus_wr(5'h04, 32'h1, 4'h1);
    bus_wr(5'h08, 32'h1, 4'h1);
    irq_in = 3'b001;
    tick(); tick(); tick();
    check("t1_not_yet", 32'(cpu_irq), 32'h0);
    tick();
    check("t1_latency", 32'(cpu_irq), 32'h1);
    bus_rd(5'h00, d); check("t1_pending", d, 32'h1);
    bus_rd(5'h0C, d); check("t1_active",  d, 32'h1);
    cpu_eoi = 3'b001;
    tick();
    check("t1_eoi_drop", 32'(cpu_irq), 32'h0);
    cpu_eoi = 3'b000;
    tick();
    bus_rd(5'h00, d); check("t1_pending_clr", d, 32'h0);
    bus_rd(5'h10, d); check("t1_status",      d, 32'h0);
    repeat (30) tick();
    irq_in = 3'b000;
    repeat (4) tick();
    check("t1_no_redeliver", 32'(cpu_irq), 32'h0);
  endtask

  typedef struct {
    logic [4:0]  off;
    logic [3:0]  strb;
    logic [31:0] wdata;
    bit          miss;
    bit          exp_rdy;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [16];

  initial begin
    logic [31:0] d;
    int          n;

    vt[0]  = '{5'h00, 4'h0, 32'h0,        0, 1, 32'h0};
    vt[1]  = '{5'h04, 4'h1, 32'h5,        0, 1, 32'h0};
    vt[2]  = '{5'h04, 4'h0, 32'h0,        0, 1, 32'h5};
    vt[3]  = '{5'h04, 4'h2, 32'h0,        0, 1, 32'h0};
    vt[4]  = '{5'h04, 4'h0, 32'h0,        0, 1, 32'h5};
    vt[5]  = '{5'h08, 4'hF, 32'hFFFFFFFF, 0, 1, 32'h0};
    vt[6]  = '{5'h08, 4'h0, 32'h0,        0, 1, 32'h7};
    vt[7]  = '{5'h0C, 4'h0, 32'h0,        0, 1, 32'h0};
    vt[8]  = '{5'h10, 4'h0, 32'h0,        0, 1, 32'h0};
    vt[9]  = '{5'h14, 4'h0, 32'h0,        0, 1, 32'h0};
    vt[10] = '{5'h00, 4'h0, 32'h0,        1, 0, 32'h0};
    vt[11] = '{5'h18, 4'h1, 32'hFFFF,     0, 1, 32'h0};
    vt[12] = '{5'h04, 4'h1, 32'hFFFFFFF8, 0, 1, 32'h0};
    vt[13] = '{5'h04, 4'h0, 32'h0,        0, 1, 32'h0};
    vt[14] = '{5'h08, 4'h1, 32'h0,        0, 1, 32'h0};
    vt[15] = '{5'h08, 4'h0, 32'h0,        0, 1, 32'h0};

    resetn = 1'b0; irq_in = '0; cpu_eoi = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    model_reset();
    repeat (3) tick();
    check("reset_cpu_irq",   32'(cpu_irq),   32'h0);
    check("reset_mem_ready", 32'(mem_ready), 32'h0);
    resetn = 1'b1;
    tick();

    // Register access table
    for (int i = 0; i < 16; i++) begin
      mem_valid = 1'b1;
      mem_addr  = (vt[i].miss ? BASE + 32'h20 : BASE) | 32'(vt[i].off);
      mem_wdata = vt[i].wdata;
      mem_wstrb = vt[i].strb;
      tick();
      check($sformatf("vec%0d_ready", i), 32'(mem_ready), 32'(vt[i].exp_rdy));
      check($sformatf("vec%0d_rdata", i), mem_rdata, vt[i].exp_rd);
      mem_valid = 1'b0; mem_wstrb = 4'h0;
      tick();
    end

    // T5: single ready pulse with held valid; misses never ready
    mem_valid = 1'b1; mem_addr = BASE + 32'h14; mem_wstrb = 4'h0;
    tick();
    check("t5_ready",        32'(mem_ready), 32'h1);
    check("t5_rdata",        mem_rdata,      32'h0);
    tick();
    check("t5_single_pulse", 32'(mem_ready), 32'h0);
    mem_valid = 1'b0;
    tick();
    mem_valid = 1'b1; mem_addr = BASE + 32'h20;
    n = 0;
    repeat (10) begin
      tick();
      if (mem_ready) n++;
    end
    check("t5_miss_ready", 32'(n), 32'h0);
    mem_valid = 1'b0;
    tick();
    bus_wr(5'h04, 32'h5, 4'h1);
    bus_wr(5'h04, 32'h0, 4'h2);
    bus_rd(5'h04, d); check("t5_wstrb_ignored", d, 32'h5);
    bus_wr(5'h04, 32'h0, 4'h1);

    // T1: basic edge delivery and handshake
    t1();

    // T2: priority and back-to-back delivery
    bus_wr(5'h04, 32'h7, 4'h1);
    bus_wr(5'h08, 32'h7, 4'h1);
    irq_in = 3'b110;
    wait_irq(3'b010, "t2_first");
    cpu_eoi = 3'b010; tick(); tick();
    cpu_eoi = 3'b000; tick();
    check("t2_gap",    32'(cpu_irq), 32'h0);
    tick();
    check("t2_second", 32'(cpu_irq), 32'h4);
    cpu_eoi = 3'b100; tick();
    cpu_eoi = 3'b000; tick(); tick();
    irq_in = 3'b000;
    repeat (4) tick();

    // T3: level line re-delivery and source drop abort
    bus_wr(5'h08, 32'h5, 4'h1);
    irq_in = 3'b010;
    wait_irq(3'b010, "t3_first");
    cpu_eoi = 3'b010; tick();
    cpu_eoi = 3'b000; tick();
    check("t3_gap",       32'(cpu_irq), 32'h0);
    tick();
    check("t3_redeliver", 32'(cpu_irq), 32'h2);
    irq_in = 3'b000;
    n = 0;
    while (cpu_irq != '0 && n < 10) begin
      tick();
      n++;
    end
    check("t3_abort_within", 32'(n <= SYNC + 1 && cpu_irq == '0), 32'h1);
    bus_rd(5'h10, d); check("t3_status_idle", d, 32'h1);

    // T4: masked pending, W1C, W1C racing a new edge
    bus_wr(5'h04, 32'h0, 4'h1);
    bus_wr(5'h08, 32'h7, 4'h1);
    irq_in = 3'b100;
    repeat (4) tick();
    bus_rd(5'h00, d); check("t4_pending", d, 32'h4);
    check("t4_masked", 32'(cpu_irq), 32'h0);
    bus_wr(5'h00, 32'h4, 4'h1);
    bus_rd(5'h00, d); check("t4_w1c", d, 32'h0);
    irq_in = 3'b000;
    repeat (4) tick();
    irq_in = 3'b100;
    tick(); tick();
    bus_wr(5'h00, 32'h4, 4'h1);
    bus_rd(5'h00, d); check("t4_edge_beats_w1c", d, 32'h4);
    bus_wr(5'h00, 32'h4, 4'h1);
    irq_in = 3'b000;
    repeat (3) tick();

    // T6: asynchronous reset during SERVICE with a bus response pending
    bus_wr(5'h04, 32'h1, 4'h1);
    bus_wr(5'h08, 32'h1, 4'h1);
    irq_in = 3'b001;
    wait_irq(3'b001, "t6_deliver");
    cpu_eoi = 3'b001; tick();
    mem_valid = 1'b1; mem_addr = BASE + 32'h10; mem_wstrb = 4'h0;
    tick();
    check("t6_ready_before", 32'(mem_ready), 32'h1);
    #2 resetn = 1'b0;
    #1;
    check("t6_async_cpu_irq", 32'(cpu_irq),   32'h0);
    check("t6_async_ready",   32'(mem_ready), 32'h0);
    check("t6_async_rdata",   mem_rdata,      32'h0);
    model_reset();
    mem_valid = 1'b0; cpu_eoi = '0; irq_in = '0;
    tick(); tick();
    resetn = 1'b1;
    bus_rd(5'h00, d); check("t6_pending", d, 32'h0);
    bus_rd(5'h04, d); check("t6_enable",  d, 32'h0);
    bus_rd(5'h08, d); check("t6_mode",    d, 32'h0);
    bus_rd(5'h10, d); check("t6_status",  d, 32'h0);
    t1();

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      int k, r;
      for (int i = 0; i < NIRQ; i++) begin
        if ($urandom % 10 == 0) irq_in[i] = ~irq_in[i];
      end
      if (cpu_irq != '0 && $urandom % 3 == 0) cpu_eoi = cpu_irq;
      else if ($urandom % 4 == 0)             cpu_eoi = '0;
      else if ($urandom % 40 == 0)            cpu_eoi = NIRQ'($urandom);
      mem_valid = ($urandom % 3 == 0);
      k = int'($urandom % 9);
      mem_addr = (k < 7) ? BASE + 32'(4 * k) : ((k == 7) ? BASE + 32'h20 : 32'h0);
      r = int'($urandom % 6);
      mem_wstrb = (r < 3) ? 4'h0 : ((r == 3) ? 4'h1 : ((r == 4) ? 4'hF : 4'h2));
      mem_wdata = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
